keypad_entry_buffer: RTL and testbench

//  Parametrised 4x4 matrix-keypad scanner and digit accumulator for the electronic lock.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_debounce.sv | 33 +++
 rtl/keypad_entry_buffer.sv | 196 +++++++++++++++++++
 tb/tb_keypad_entry_buffer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key codes and key-map helper for the keypad entry buffer.
package keypad_pkg;

    typedef enum logic [1:0] {
        KIND_CONFIRM = 2'd0,
        KIND_CLEAR   = 2'd1,
        KIND_TIMEOUT = 2'd2
    } kind_e;

    typedef enum logic [2:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_DECODE,
        ST_EMIT,
        ST_WAIT_RELEASE
    } state_e;

    localparam logic [3:0] KEY_CONFIRM = 4'hA;
    localparam logic [3:0] KEY_CLEAR   = 4'hB;
    localparam logic [3:0] KEY_BKSP    = 4'hC;
    localparam logic [3:0] DIG_EMPTY   = 4'hF;
    localparam logic [3:0] DIG_TIMEOUT = 4'hE;

    // Entry {row,col}: r0 1 2 3 C, r1 4 5 6 D, r2 7 8 9 E, r3 A 0 B F.
    localparam logic [15:0][3:0] KEY_TABLE = 64'hFB0A_E987_D654_C321;

    function automatic logic [3:0] key_map(
        input logic [1:0] row,
        input logic [3:0] cols
    );
        logic [1:0] c;
        case (cols)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            4'b0111: c = 2'd3;
            default: c = 2'd0;
        endcase
        return KEY_TABLE[{row, c}];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-pattern counter: raises stable once N equal consecutive samples are seen.
module keypad_debounce #(
    parameter int N = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [3:0] sample,
    output logic       stable
);

    localparam int CW = $clog2(N + 1) + 1;

    logic [3:0]    last_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] run;

    always_comb begin
        run    = (sample == last_q) ? cnt_q + CW'(1) : CW'(1);
        stable = (run >= CW'(N));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            last_q <= 4'hF;
            cnt_q  <= '0;
        end else begin
            last_q <= sample;
            cnt_q  <= stable ? CW'(N) : run;
        end
    end

endmodule

// File: rtl/keypad_entry_buffer.sv
// 4x4 keypad scanner and digit accumulator with valid/ready result port.
// KEYPAD_BACKSPACE_EN: key C deletes the newest digit instead of being ignored.
module keypad_entry_buffer
    import keypad_pkg::*;
#(
    parameter int DIGITS       = 20,
    parameter int DEBOUNCE_CYC = 100,
    parameter int TIMEOUT_CYC  = 500,
    parameter int SCAN_CYC     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [3:0]                      col_matriz,
    output logic [3:0]                      lin_matriz,
    input  logic                            digitos_ready,
    output logic                            digitos_valid,
    output kind_e                           digitos_kind,
    output logic [DIGITS-1:0][3:0]          digitos_value,
    output logic [$clog2(DIGITS+1)-1:0]     digit_count
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

    state_e                  state_q, state_d;
    logic [1:0]              row_q;
    logic [SW-1:0]           scan_cnt_q;
    logic [IW-1:0]           idle_q;
    logic [3:0]              pat_q;
    logic [DIGITS-1:0][3:0]  buf_q;
    logic [CW-1:0]           count_q;
    logic                    valid_q;
    kind_e                   kind_q;
    logic [DIGITS-1:0][3:0]  value_q;

    logic                    sr;
    logic                    col_idle;
    logic                    press_stable;
    logic                    rel_stable;
    logic                    timeout_hit;
    logic                    multi;
    logic [3:0]              not_p;
    logic [3:0]              code;
    logic                    push;
    logic                    bksp;
    logic                    load;
    logic                    accept;
    kind_e                   load_kind;
    logic [DIGITS-1:0][3:0]  load_value;

    assign sr       = rst || !enable;
    assign col_idle = (col_matriz == 4'hF);
    assign not_p    = ~pat_q;
    assign multi    = |(not_p & (not_p - 4'd1));
    assign code     = key_map(row_q, pat_q);
    assign timeout_hit = (count_q != '0) && col_idle &&
                         (idle_q == IW'(TIMEOUT_CYC - 1));

    assign lin_matriz    = ~(4'b0001 << row_q);
    assign digitos_valid = valid_q;
    assign digitos_kind  = kind_q;
    assign digitos_value = value_q;
    assign digit_count   = count_q;

    keypad_debounce #(.N(DEBOUNCE_CYC)) press_db (
        .clk    (clk),
        .rst    (sr),
        .clear  (state_q != ST_DEBOUNCE),
        .sample (col_matriz),
        .stable (press_stable)
    );

    keypad_debounce #(.N(DEBOUNCE_CYC)) release_db (
        .clk    (clk),
        .rst    (sr),
        .clear  (state_q != ST_WAIT_RELEASE),
        .sample (col_matriz),
        .stable (rel_stable)
    );

    always_ff @(posedge clk) begin
        if (sr) state_q <= ST_SCAN;
        else    state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        bksp       = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        load_kind  = KIND_CONFIRM;
        load_value = buf_q;
        unique case (state_q)
            ST_SCAN: begin
                if (!col_idle) begin
                    state_d = ST_DEBOUNCE;
                end else if (timeout_hit) begin
                    load       = 1'b1;
                    load_kind  = KIND_TIMEOUT;
                    load_value = {DIGITS{DIG_TIMEOUT}};
                    state_d    = ST_EMIT;
                end
            end
            ST_DEBOUNCE: begin
                if (col_idle)          state_d = ST_SCAN;
                else if (press_stable) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_WAIT_RELEASE;
                if (multi) begin
                    state_d = ST_WAIT_RELEASE;
                end else if (code <= 4'd9) begin
                    push = 1'b1;
                end else if (code == KEY_CONFIRM) begin
                    load    = 1'b1;
                    state_d = ST_EMIT;
                end else if (code == KEY_CLEAR) begin
                    load       = 1'b1;
                    load_kind  = KIND_CLEAR;
                    load_value = {DIGITS{KEY_CLEAR}};
                    state_d    = ST_EMIT;
`ifdef KEYPAD_BACKSPACE_EN
                end else if (code == KEY_BKSP) begin
                    bksp = (count_q != '0);
`endif
                end
            end
            ST_EMIT: begin
                if (digitos_ready) begin
                    accept  = 1'b1;
                    state_d = (kind_q == KIND_TIMEOUT) ?
                              ST_SCAN : ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (rel_stable && col_idle) state_d = ST_SCAN;
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sr) begin
            row_q      <= 2'd0;
            scan_cnt_q <= '0;
            idle_q     <= '0;
            pat_q      <= 4'hF;
            buf_q      <= '1;
            count_q    <= '0;
            valid_q    <= 1'b0;
            kind_q     <= KIND_CONFIRM;
            value_q    <= '1;
        end else begin
            if (state_q == ST_SCAN && col_idle) begin
                if (scan_cnt_q == SW'(SCAN_CYC - 1)) begin
                    scan_cnt_q <= '0;
                    row_q      <= row_q + 2'd1;
                end else begin
                    scan_cnt_q <= scan_cnt_q + SW'(1);
                end
            end
            if (state_q == ST_SCAN && col_idle &&
                count_q != '0 && !timeout_hit)
                idle_q <= idle_q + IW'(1);
            else
                idle_q <= '0;
            if (state_q == ST_DEBOUNCE) pat_q <= col_matriz;
            if (push) begin
                for (int i = 0; i < DIGITS - 1; i++)
                    buf_q[i] <= buf_q[i+1];
                buf_q[DIGITS-1] <= code;
                if (count_q != CW'(DIGITS)) count_q <= count_q + CW'(1);
            end
            if (bksp) begin
                for (int i = 1; i < DIGITS; i++)
                    buf_q[i] <= buf_q[i-1];
                buf_q[0] <= DIG_EMPTY;
                count_q  <= count_q - CW'(1);
            end
            if (load) begin
                valid_q <= 1'b1;
                kind_q  <= load_kind;
                value_q <= load_value;
            end
            if (accept) begin
                valid_q <= 1'b0;
                buf_q   <= '1;
                count_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer with a behavioural 4x4 keypad.
module tb_keypad_entry_buffer;
    import keypad_pkg::*;

    localparam int DIGITS = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [3:0]            col_matriz;
    logic [3:0]            lin_matriz;
    logic                  digitos_ready;
    logic                  digitos_valid;
    kind_e                 digitos_kind;
    logic [DIGITS-1:0][3:0] digitos_value;
    logic [2:0]            digit_count;

    logic [15:0] pressed = '0;
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;
    kind_e       last_kind = KIND_CONFIRM;
    logic [15:0] last_value = '0;

    keypad_entry_buffer #(
        .DIGITS(DIGITS), .DEBOUNCE_CYC(4),
        .TIMEOUT_CYC(20), .SCAN_CYC(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .col_matriz(col_matriz), .lin_matriz(lin_matriz),
        .digitos_ready(digitos_ready), .digitos_valid(digitos_valid),
        .digitos_kind(digitos_kind), .digitos_value(digitos_value),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // Pressed switch at (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col_matriz = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!lin_matriz[r]) col_matriz = col_matriz & ~pressed[r*4 +: 4];
    end

    always @(posedge clk) begin
        if (digitos_valid && digitos_ready) begin
            pulses     <= pulses + 1;
            last_kind  <= digitos_kind;
            last_value <= digitos_value;
        end
    end

    function automatic int key_idx(input logic [3:0] k);
        case (k)
            4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hC: return 3;
            4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hD: return 7;
            4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hE: return 11;
            4'hA: return 12; 4'h0: return 13; 4'hB: return 14; default: return 15;
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] k, input int hold);
        pressed = 16'h1 << key_idx(k);
        cycles(hold);
        pressed = '0;
        cycles(12);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; digitos_ready = 1'b1; pressed = '0;
        cycles(3);
        total++;
        if (lin_matriz !== 4'b1110 || digitos_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: lin=%b valid=%b required 1110 0",
                     lin_matriz, digitos_valid);
        end
        total++;
        if (digitos_value !== 16'hFFFF || digit_count !== 3'd0 ||
            digitos_kind !== KIND_CONFIRM) begin
            bad++;
            $display("FAIL reset_val: value=%h count=%0d kind=%0d required ffff 0 0",
                     digitos_value, digit_count, digitos_kind);
        end
        rst = 1'b0;
        cycles(2);
    endtask

    task automatic test_confirm();
        int p0;
        p0 = pulses;
        press_key(4'h1, 14);
        press_key(4'h2, 14);
        press_key(4'h3, 14);
        total++;
        if (digit_count !== 3'd3) begin
            bad++;
            $display("FAIL confirm_count: got %0d required 3", digit_count);
        end
        press_key(4'hA, 14);
        total++;
        if (pulses - p0 !== 1 || last_kind !== KIND_CONFIRM) begin
            bad++;
            $display("FAIL confirm_pulse: pulses=%0d kind=%0d required 1 0",
                     pulses - p0, last_kind);
        end
        total++;
        if (last_value !== 16'h321F || digit_count !== 3'd0) begin
            bad++;
            $display("FAIL confirm_value: value=%h count=%0d required 321f 0",
                     last_value, digit_count);
        end
    endtask

    task automatic test_bounce();
        int n;
        n = 0;
        while (lin_matriz !== 4'b1101 && n < 8) begin
            cycles(1);
            n++;
        end
        pressed = 16'h1 << key_idx(4'h5);
        cycles(2);
        pressed = '0;
        cycles(10);
        total++;
        if (digit_count !== 3'd0) begin
            bad++;
            $display("FAIL bounce_reject: count=%0d required 0", digit_count);
        end
        press_key(4'h5, 14);
        total++;
        if (digit_count !== 3'd1) begin
            bad++;
            $display("FAIL bounce_accept: count=%0d required 1", digit_count);
        end
        press_key(4'hA, 14);
        total++;
        if (last_value !== 16'h5FFF) begin
            bad++;
            $display("FAIL bounce_value: value=%h required 5fff", last_value);
        end
    endtask

    task automatic test_ignored();
        pressed = (16'h1 << key_idx(4'h1)) | (16'h1 << key_idx(4'h2));
        cycles(14);
        pressed = '0;
        cycles(12);
        press_key(4'hD, 14);
        total++;
        if (digit_count !== 3'd0 || digitos_valid !== 1'b0) begin
            bad++;
            $display("FAIL ignored_keys: count=%0d valid=%b required 0 0",
                     digit_count, digitos_valid);
        end
    endtask

    task automatic test_saturate();
        press_key(4'h1, 14);
        press_key(4'h2, 14);
        press_key(4'h3, 14);
        press_key(4'h4, 14);
        press_key(4'h5, 14);
        total++;
        if (digit_count !== 3'd4) begin
            bad++;
            $display("FAIL saturate_count: count=%0d required 4", digit_count);
        end
        press_key(4'hA, 14);
        total++;
        if (last_value !== 16'h5432) begin
            bad++;
            $display("FAIL saturate_value: value=%h required 5432", last_value);
        end
    endtask

    task automatic test_clear();
        int p0;
        press_key(4'h6, 14);
        p0 = pulses;
        press_key(4'hB, 14);
        total++;
        if (pulses - p0 !== 1 || last_kind !== KIND_CLEAR ||
            last_value !== 16'hBBBB || digit_count !== 3'd0) begin
            bad++;
            $display("FAIL clear: n=%0d kind=%0d value=%h count=%0d required 1 1 bbbb 0",
                     pulses - p0, last_kind, last_value, digit_count);
        end
    endtask

    task automatic test_timeout();
        int p0;
        int n;
        press_key(4'h7, 14);
        p0 = pulses;
        cycles(8);
        total++;
        if (pulses !== p0) begin
            bad++;
            $display("FAIL timeout_early: pulses=%0d required %0d", pulses, p0);
        end
        n = 0;
        while (pulses == p0 && n < 40) begin
            cycles(1);
            n++;
        end
        total++;
        if (pulses - p0 !== 1 || last_kind !== KIND_TIMEOUT) begin
            bad++;
            $display("FAIL timeout_pulse: n=%0d kind=%0d required 1 2",
                     pulses - p0, last_kind);
        end
        total++;
        if (last_value !== 16'hEEEE || digit_count !== 3'd0) begin
            bad++;
            $display("FAIL timeout_value: value=%h count=%0d required eeee 0",
                     last_value, digit_count);
        end
        cycles(40);
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL timeout_empty: pulses=%0d required 1", pulses - p0);
        end
    endtask

    task automatic test_ready_hold();
        int p0;
        int n;
        press_key(4'h9, 14);
        digitos_ready = 1'b0;
        p0 = pulses;
        pressed = 16'h1 << key_idx(4'hA);
        n = 0;
        while (!digitos_valid && n < 20) begin
            cycles(1);
            n++;
        end
        total++;
        if (digitos_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_wait: valid=%b required 1", digitos_valid);
        end
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            total++;
            if (digitos_valid !== 1'b1 || digitos_value !== 16'h9FFF ||
                digitos_kind !== KIND_CONFIRM || digit_count !== 3'd1) begin
                bad++;
                $display("FAIL hold_%0d: valid=%b value=%h kind=%0d count=%0d required 1 9fff 0 1",
                         i, digitos_valid, digitos_value, digitos_kind, digit_count);
            end
        end
        pressed = '0;
        digitos_ready = 1'b1;
        cycles(1);
        total++;
        if (digitos_valid !== 1'b0 || digit_count !== 3'd0 || pulses - p0 !== 1) begin
            bad++;
            $display("FAIL hold_release: valid=%b count=%0d n=%0d required 0 0 1",
                     digitos_valid, digit_count, pulses - p0);
        end
        cycles(12);
    endtask

    task automatic test_backspace();
        press_key(4'h7, 14);
        press_key(4'h8, 14);
        press_key(4'hC, 14);
        total++;
`ifdef KEYPAD_BACKSPACE_EN
        if (digit_count !== 3'd1) begin
            bad++;
            $display("FAIL bksp_count: count=%0d required 1", digit_count);
        end
`else
        if (digit_count !== 3'd2) begin
            bad++;
            $display("FAIL bksp_count: count=%0d required 2", digit_count);
        end
`endif
        press_key(4'hA, 14);
        total++;
`ifdef KEYPAD_BACKSPACE_EN
        if (last_value !== 16'h7FFF) begin
            bad++;
            $display("FAIL bksp_value: value=%h required 7fff", last_value);
        end
`else
        if (last_value !== 16'h87FF) begin
            bad++;
            $display("FAIL bksp_value: value=%h required 87ff", last_value);
        end
`endif
    endtask

    task automatic test_enable();
        int p0;
        int n;
        press_key(4'h3, 14);
        digitos_ready = 1'b0;
        p0 = pulses;
        pressed = 16'h1 << key_idx(4'hA);
        n = 0;
        while (!digitos_valid && n < 20) begin
            cycles(1);
            n++;
        end
        total++;
        if (digitos_valid !== 1'b1) begin
            bad++;
            $display("FAIL enable_wait: valid=%b required 1", digitos_valid);
        end
        pressed = '0;
        enable = 1'b0;
        cycles(1);
        total++;
        if (digitos_valid !== 1'b0 || digit_count !== 3'd0 ||
            lin_matriz !== 4'b1110 || digitos_value !== 16'hFFFF) begin
            bad++;
            $display("FAIL enable_drop: valid=%b count=%0d lin=%b value=%h required 0 0 1110 ffff",
                     digitos_valid, digit_count, lin_matriz, digitos_value);
        end
        enable = 1'b1;
        digitos_ready = 1'b1;
        cycles(15);
        total++;
        if (pulses !== p0 || digitos_valid !== 1'b0) begin
            bad++;
            $display("FAIL enable_lost: pulses=%0d valid=%b required %0d 0",
                     pulses, digitos_valid, p0);
        end
    endtask

    initial begin
        test_reset();
        test_confirm();
        test_bounce();
        test_ignored();
        test_saturate();
        test_clear();
        test_timeout();
        test_ready_hold();
        test_backspace();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
